// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU.
// Holds dispatched ALU ops until both operands are known, snoops the ALU and LSB
// result buses for missing operands, and issues one ready op per cycle.
// Build option: ALU_RS_WAKEUP_BYPASS_EN -- a CDB broadcast can make an operand
// ready in its own cycle, with the value taken straight from the bus.
module alu_rs #(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    input  logic [3:0]           dispatch_op,
    input  logic [31:0]          dispatch_vj,
    input  logic                 dispatch_qj_valid,
    input  logic [ROB_WIDTH-1:0] dispatch_qj,
    input  logic [31:0]          dispatch_vk,
    input  logic                 dispatch_qk_valid,
    input  logic [ROB_WIDTH-1:0] dispatch_qk,
    input  logic [ROB_WIDTH-1:0] dispatch_dest,
    output logic                 full,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_WIDTH-1:0] cdb_alu_dest,
    input  logic [31:0]          cdb_alu_value,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_lsb_dest,
    input  logic [31:0]          cdb_lsb_value,
    output logic                 alu_enable,
    output logic [3:0]           alu_op,
    output logic [31:0]          alu_value_1,
    output logic [31:0]          alu_value_2,
    output logic [ROB_WIDTH-1:0] alu_dest
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned IDX_W  = $clog2(RS_SIZE);

    typedef struct packed {
        logic                 busy;
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    vj;
        logic                 qj_valid;
        logic [ROB_WIDTH-1:0] qj;
        logic [DATA_W-1:0]    vk;
        logic                 qk_valid;
        logic [ROB_WIDTH-1:0] qk;
        logic [ROB_WIDTH-1:0] dest;
    } rs_entry_t;

    rs_entry_t [RS_SIZE-1:0] entry_q;
    logic [ROB_WIDTH-1:0]    issue_dest_q;

    logic [RS_SIZE-1:0]             busy_c;
    logic [RS_SIZE-1:0]             ready_c;
    logic [RS_SIZE-1:0]             j_hit_c;
    logic [RS_SIZE-1:0]             k_hit_c;
    logic [RS_SIZE-1:0][DATA_W-1:0] j_val_c;
    logic [RS_SIZE-1:0][DATA_W-1:0] k_val_c;
    logic                           d_j_hit_c;
    logic                           d_k_hit_c;
    logic [DATA_W-1:0]              d_j_val_c;
    logic [DATA_W-1:0]              d_k_val_c;
    logic                           issue_found_c;
    logic [IDX_W-1:0]               issue_idx_c;
    logic                           free_found_c;
    logic [IDX_W-1:0]               free_idx_c;
    logic [DATA_W-1:0]              issue_v1_c;
    logic [DATA_W-1:0]              issue_v2_c;
    rs_entry_t                      new_entry_c;

    // Tag lookup on both result buses; the ALU bus wins when both match.
    function automatic logic [DATA_W:0] cdb_match(
        input logic [ROB_WIDTH-1:0] tag,
        input logic                 a_valid,
        input logic [ROB_WIDTH-1:0] a_dest,
        input logic [DATA_W-1:0]    a_value,
        input logic                 l_valid,
        input logic [ROB_WIDTH-1:0] l_dest,
        input logic [DATA_W-1:0]    l_value
    );
        logic [DATA_W:0] res;
        res = '0;
        if (a_valid && (tag == a_dest)) begin
            res = {1'b1, a_value};
        end else if (l_valid && (tag == l_dest)) begin
            res = {1'b1, l_value};
        end
        return res;
    endfunction

    // Per-entry bus snoop, ready test, issue pick and free-slot pick on pre-edge state.
    always_comb begin
        busy_c        = '0;
        ready_c       = '0;
        j_hit_c       = '0;
        k_hit_c       = '0;
        j_val_c       = '0;
        k_val_c       = '0;
        issue_found_c = 1'b0;
        issue_idx_c   = '0;
        free_found_c  = 1'b0;
        free_idx_c    = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            busy_c[i] = entry_q[i].busy;
            {j_hit_c[i], j_val_c[i]} = cdb_match(entry_q[i].qj, cdb_alu_valid, cdb_alu_dest,
                                                 cdb_alu_value, cdb_lsb_valid, cdb_lsb_dest,
                                                 cdb_lsb_value);
            {k_hit_c[i], k_val_c[i]} = cdb_match(entry_q[i].qk, cdb_alu_valid, cdb_alu_dest,
                                                 cdb_alu_value, cdb_lsb_valid, cdb_lsb_dest,
                                                 cdb_lsb_value);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready_c[i] = entry_q[i].busy && (!entry_q[i].qj_valid || j_hit_c[i])
                                         && (!entry_q[i].qk_valid || k_hit_c[i]);
`else
            ready_c[i] = entry_q[i].busy && !entry_q[i].qj_valid && !entry_q[i].qk_valid;
`endif
            if (ready_c[i] && !issue_found_c) begin
                issue_found_c = 1'b1;
                issue_idx_c   = IDX_W'(i);
            end
            if (!entry_q[i].busy && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end

        issue_v1_c = entry_q[issue_idx_c].vj;
        issue_v2_c = entry_q[issue_idx_c].vk;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        if (entry_q[issue_idx_c].qj_valid) issue_v1_c = j_val_c[issue_idx_c];
        if (entry_q[issue_idx_c].qk_valid) issue_v2_c = k_val_c[issue_idx_c];
`endif
    end

    // Build the entry written by dispatch, capturing a same-cycle broadcast of its tags.
    always_comb begin
        {d_j_hit_c, d_j_val_c} = cdb_match(dispatch_qj, cdb_alu_valid, cdb_alu_dest,
                                           cdb_alu_value, cdb_lsb_valid, cdb_lsb_dest,
                                           cdb_lsb_value);
        {d_k_hit_c, d_k_val_c} = cdb_match(dispatch_qk, cdb_alu_valid, cdb_alu_dest,
                                           cdb_alu_value, cdb_lsb_valid, cdb_lsb_dest,
                                           cdb_lsb_value);
        new_entry_c          = '0;
        new_entry_c.busy     = 1'b1;
        new_entry_c.op       = dispatch_op;
        new_entry_c.qj       = dispatch_qj;
        new_entry_c.qk       = dispatch_qk;
        new_entry_c.dest     = dispatch_dest;
        new_entry_c.vj       = (dispatch_qj_valid && d_j_hit_c) ? d_j_val_c : dispatch_vj;
        new_entry_c.qj_valid = dispatch_qj_valid && !d_j_hit_c;
        new_entry_c.vk       = (dispatch_qk_valid && d_k_hit_c) ? d_k_val_c : dispatch_vk;
        new_entry_c.qk_valid = dispatch_qk_valid && !d_k_hit_c;
    end

    assign full = &busy_c;

    // Entry state and ALU-side registers: reset/flush, wakeup, issue, dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q      <= '0;
            alu_enable   <= 1'b0;
            alu_op       <= '0;
            alu_value_1  <= '0;
            alu_value_2  <= '0;
            issue_dest_q <= '0;
            alu_dest     <= '0;
        end else if (flush) begin
            entry_q      <= '0;
            alu_enable   <= 1'b0;
            alu_op       <= '0;
            alu_value_1  <= '0;
            alu_value_2  <= '0;
            issue_dest_q <= '0;
            alu_dest     <= '0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (entry_q[i].busy && entry_q[i].qj_valid && j_hit_c[i]) begin
                    entry_q[i].vj       <= j_val_c[i];
                    entry_q[i].qj_valid <= 1'b0;
                end
                if (entry_q[i].busy && entry_q[i].qk_valid && k_hit_c[i]) begin
                    entry_q[i].vk       <= k_val_c[i];
                    entry_q[i].qk_valid <= 1'b0;
                end
            end
            if (issue_found_c) begin
                entry_q[issue_idx_c].busy <= 1'b0;
                alu_op                    <= entry_q[issue_idx_c].op;
                alu_value_1               <= issue_v1_c;
                alu_value_2               <= issue_v2_c;
                issue_dest_q              <= entry_q[issue_idx_c].dest;
            end
            if (dispatch_valid && free_found_c) begin
                entry_q[free_idx_c] <= new_entry_c;
            end
            alu_enable <= issue_found_c;
            alu_dest   <= issue_dest_q;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs; expected issues are queued at dispatch
// and compared when alu_enable is seen, alu_dest one cycle later.
module tb_alu_rs;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  dest;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        dispatch_valid;
    logic [3:0]  dispatch_op;
    logic [31:0] dispatch_vj;
    logic        dispatch_qj_valid;
    logic [3:0]  dispatch_qj;
    logic [31:0] dispatch_vk;
    logic        dispatch_qk_valid;
    logic [3:0]  dispatch_qk;
    logic [3:0]  dispatch_dest;
    logic        full;
    logic        cdb_alu_valid;
    logic [3:0]  cdb_alu_dest;
    logic [31:0] cdb_alu_value;
    logic        cdb_lsb_valid;
    logic [3:0]  cdb_lsb_dest;
    logic [31:0] cdb_lsb_value;
    logic        alu_enable;
    logic [3:0]  alu_op;
    logic [31:0] alu_value_1;
    logic [31:0] alu_value_2;
    logic [3:0]  alu_dest;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic dest_pending = 1'b0;
    logic [3:0] pend_dest = '0;

    alu_rs #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_vj(dispatch_vj), .dispatch_qj_valid(dispatch_qj_valid),
        .dispatch_qj(dispatch_qj), .dispatch_vk(dispatch_vk),
        .dispatch_qk_valid(dispatch_qk_valid), .dispatch_qk(dispatch_qk),
        .dispatch_dest(dispatch_dest), .full(full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_dest(cdb_alu_dest),
        .cdb_alu_value(cdb_alu_value), .cdb_lsb_valid(cdb_lsb_valid),
        .cdb_lsb_dest(cdb_lsb_dest), .cdb_lsb_value(cdb_lsb_value),
        .alu_enable(alu_enable), .alu_op(alu_op), .alu_value_1(alu_value_1),
        .alu_value_2(alu_value_2), .alu_dest(alu_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        dispatch_valid    = 1'b0;
        dispatch_op       = '0;
        dispatch_vj       = '0;
        dispatch_qj_valid = 1'b0;
        dispatch_qj       = '0;
        dispatch_vk       = '0;
        dispatch_qk_valid = 1'b0;
        dispatch_qk       = '0;
        dispatch_dest     = '0;
        cdb_alu_valid     = 1'b0;
        cdb_alu_dest      = '0;
        cdb_alu_value     = '0;
        cdb_lsb_valid     = 1'b0;
        cdb_lsb_dest      = '0;
        cdb_lsb_value     = '0;
    endtask

    task automatic drive_dispatch(input logic [3:0] op, input logic [31:0] vj,
                                  input logic qjv, input logic [3:0] qj,
                                  input logic [31:0] vk, input logic qkv,
                                  input logic [3:0] qk, input logic [3:0] dest);
        dispatch_valid    = 1'b1;
        dispatch_op       = op;
        dispatch_vj       = vj;
        dispatch_qj_valid = qjv;
        dispatch_qj       = qj;
        dispatch_vk       = vk;
        dispatch_qk_valid = qkv;
        dispatch_qk       = qk;
        dispatch_dest     = dest;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [3:0] dest);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.dest = dest;
        exp_q.push_back(e);
    endtask

    task automatic wait_enable(input string tag, input int max_cyc);
        int n = 0;
        while (!alu_enable && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!alu_enable) check_eq(tag, 32'(alu_enable), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Issue monitor: pop expected op on every alu_enable, check its tag a cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                dest_pending = 1'b0;
            end else begin
                if (dest_pending) begin
                    check_eq("alu_dest", 32'(alu_dest), 32'(pend_dest));
                    dest_pending = 1'b0;
                end
                if (alu_enable) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_issue", 32'(alu_enable), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("alu_op", 32'(alu_op), 32'(mon_e.op));
                        check_eq("alu_value_1", alu_value_1, mon_e.v1);
                        check_eq("alu_value_2", alu_value_2, mon_e.v2);
                        pend_dest    = mon_e.dest;
                        dest_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_eq("reset_enable", 32'(alu_enable), 32'd0);
        check_eq("reset_full", 32'(full), 32'd0);
        check_eq("reset_dest", 32'(alu_dest), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ready dispatch: dispatch edge, then issue edge.
        drive_dispatch(4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        push_exp(4'd0, 32'd5, 32'd7, 4'd3);
        @(negedge clk);
        idle_inputs();
        check_eq("ready_no_early_issue", 32'(alu_enable), 32'd0);
        @(negedge clk);
        check_eq("ready_issue_lat", 32'(alu_enable), 32'd1);
        drain("ready_drain");

        // Wakeup from the LSB bus two cycles after dispatch.
        drive_dispatch(4'd1, 32'd0, 1'b1, 4'd2, 32'h20, 1'b0, 4'd0, 4'd4);
        push_exp(4'd1, 32'h10, 32'h20, 4'd4);
        @(negedge clk);
        idle_inputs();
        check_eq("wake_hold0", 32'(alu_enable), 32'd0);
        @(negedge clk);
        check_eq("wake_hold1", 32'(alu_enable), 32'd0);
        cdb_lsb_valid = 1'b1; cdb_lsb_dest = 4'd2; cdb_lsb_value = 32'h10;
        @(negedge clk);
        idle_inputs();
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        check_eq("wake_issue_lat", 32'(alu_enable), 32'd1);
`else
        check_eq("wake_no_early_issue", 32'(alu_enable), 32'd0);
        @(negedge clk);
        check_eq("wake_issue_lat", 32'(alu_enable), 32'd1);
`endif
        drain("wake_drain");

        // Dispatch/CDB race on both buses; ALU bus value must win.
        drive_dispatch(4'd2, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd5);
        cdb_alu_valid = 1'b1; cdb_alu_dest = 4'd6; cdb_alu_value = 32'd9;
        cdb_lsb_valid = 1'b1; cdb_lsb_dest = 4'd6; cdb_lsb_value = 32'h77;
        push_exp(4'd2, 32'd1, 32'd9, 4'd5);
        @(negedge clk);
        idle_inputs();
        check_eq("race_no_early_issue", 32'(alu_enable), 32'd0);
        @(negedge clk);
        check_eq("race_issue_lat", 32'(alu_enable), 32'd1);
        drain("race_drain");

        // Fill all entries waiting on tag 7, then release them in one broadcast.
        for (int i = 0; i < 8; i++) begin
            drive_dispatch(4'(i), 32'hDEAD, 1'b1, 4'd7, 32'(i), 1'b0, 4'd0, 4'(i));
            push_exp(4'(i), 32'hAB, 32'(i), 4'(i));
            @(negedge clk);
        end
        idle_inputs();
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_no_issue", 32'(alu_enable), 32'd0);
        cdb_alu_valid = 1'b1; cdb_alu_dest = 4'd7; cdb_alu_value = 32'hAB;
        @(negedge clk);
        idle_inputs();
        wait_enable("fill_issue_timeout", 4);
        check_eq("fill_full_drop", 32'(full), 32'd0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check_eq("fill_throughput", 32'(alu_enable), 32'd1);
        end
        drain("fill_drain");

        // Flush with four waiting entries plus a same-cycle dispatch.
        for (int i = 0; i < 4; i++) begin
            drive_dispatch(4'd6, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(8 + i));
            @(negedge clk);
        end
        drive_dispatch(4'd7, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd12);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle_inputs();
        check_eq("flush_full", 32'(full), 32'd0);
        check_eq("flush_enable", 32'(alu_enable), 32'd0);
        check_eq("flush_dest", 32'(alu_dest), 32'd0);
        repeat (2) @(negedge clk);
        cdb_alu_valid = 1'b1; cdb_alu_dest = 4'd9; cdb_alu_value = 32'd1;
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("flush_quiet", 32'(alu_enable), 32'd0);
        end

        // Dispatch, wakeup and issue in the same cycle.
        drive_dispatch(4'd3, 32'd0, 1'b1, 4'd10, 32'd2, 1'b0, 4'd0, 4'd1);
        @(negedge clk);
        drive_dispatch(4'd4, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd2);
        @(negedge clk);
        drive_dispatch(4'd5, 32'd6, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 4'd6);
        cdb_alu_valid = 1'b1; cdb_alu_dest = 4'd10; cdb_alu_value = 32'h55;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        push_exp(4'd3, 32'h55, 32'd2, 4'd1);
        push_exp(4'd4, 32'd3, 32'd4, 4'd2);
`else
        push_exp(4'd4, 32'd3, 32'd4, 4'd2);
        push_exp(4'd3, 32'h55, 32'd2, 4'd1);
`endif
        push_exp(4'd5, 32'd6, 32'd8, 4'd6);
        @(negedge clk);
        idle_inputs();
        drain("simul_drain");

        // Asynchronous reset mid-run while an issue is on the outputs.
        for (int i = 0; i < 8; i++) begin
            drive_dispatch(4'(i), 32'd0, 1'b1, 4'd11, 32'(i), 1'b0, 4'd0, 4'(i));
            push_exp(4'(i), 32'h3C, 32'(i), 4'(i));
            @(negedge clk);
        end
        idle_inputs();
        check_eq("rst_pre_full", 32'(full), 32'd1);
        cdb_alu_valid = 1'b1; cdb_alu_dest = 4'd11; cdb_alu_value = 32'h3C;
        @(negedge clk);
        idle_inputs();
        wait_enable("rst_pre_issue_timeout", 4);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_enable", 32'(alu_enable), 32'd0);
        check_eq("rst_async_full", 32'(full), 32'd0);
        check_eq("rst_async_dest", 32'(alu_dest), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("rst_quiet", 32'(alu_enable), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
